// File: rtl/analog_capture_pkg.sv
// Shared state encoding and default parameters for the analog capture block.
package analog_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam int DEF_WIDTH      = 6;
    localparam int DEF_FILTER_LEN = 4;
    localparam int DEF_SAMPLE_DIV = 16;

    localparam int CNT_W  = 9;   // holds 256 without wrapping
    localparam int DIV_W  = 16;
    localparam int FCNT_W = 4;

endpackage

// File: rtl/sync_filter.sv
// One analog line: two-flop synchronizer followed by a stability filter that
// only follows the raw value after FILTER_LEN consecutive disagreeing cycles.
module sync_filter
    import analog_capture_pkg::*;
#(
    parameter int FILTER_LEN = DEF_FILTER_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam logic [FCNT_W-1:0] LAST = FCNT_W'(FILTER_LEN - 1);

    logic              s1;
    logic              s2;
    logic [FCNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (s2 == dout) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                dout <= s2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/analog_capture.sv
// Burst sampler for the filtered analog lines: a fixed-cadence FSM captures
// the filtered word into a valid/ready output register.
module analog_capture
    import analog_capture_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int FILTER_LEN = DEF_FILTER_LEN,
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] analog_in,
    input  logic             start,
    input  logic [7:0]       burst_len,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             overrun,
    output state_t           dbg_state
);

    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SAMPLE_DIV - 1);

    state_t            state;
    state_t            state_nx;
    logic [DIV_W-1:0]  div;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  len;
    logic [WIDTH-1:0]  filt;
    logic              start_ok;
    logic              sample_pt;
    logic              reload;
    logic              last;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sync_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
            .clk  (clk),
            .rst  (rst),
            .din  (analog_in[i]),
            .dout (filt[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (start) state_nx = ST_WAIT;
            ST_WAIT:   if (div == '0) state_nx = ST_SAMPLE;
            ST_SAMPLE: state_nx = ST_HOLD;
            ST_HOLD: begin
                if (!last)           state_nx = ST_WAIT;
                else if (!out_valid) state_nx = ST_IDLE;
            end
            default:   state_nx = ST_IDLE;
        endcase
    end

    // The sample point is the edge entering SAMPLE, so the captured word is
    // already presented while the FSM sits in SAMPLE.
    always_comb begin
        last      = (cnt == len);
        busy      = (state != ST_IDLE);
        start_ok  = (state == ST_IDLE) && start;
        sample_pt = (state == ST_WAIT) && (div == '0);
        reload    = (state == ST_HOLD) && !last;
        done      = (state == ST_HOLD) && last && !out_valid;
        dbg_state = state;
    end

    // Handshake: a word moves on every edge where out_valid && out_ready;
    // out_data is frozen while out_valid is high, and a sample point that
    // coincides with acceptance reloads the register instead of overrunning.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div       <= '0;
            cnt       <= '0;
            len       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (start_ok) begin
                len     <= (burst_len == 8'd0) ? 9'd256 : {1'b0, burst_len};
                cnt     <= '0;
                div     <= DIV_LOAD;
                overrun <= 1'b0;
            end else if (reload) begin
                div <= DIV_LOAD;
            end else if (state == ST_WAIT && div != '0) begin
                div <= div - 1'b1;
            end

            if (sample_pt) cnt <= cnt + 1'b1;

            if (sample_pt && (!out_valid || out_ready)) begin
                out_data  <= filt;
                out_valid <= 1'b1;
            end else begin
                if (sample_pt)              overrun   <= 1'b1;
                if (out_valid && out_ready) out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_analog_capture.sv
// Randomized bench for analog_capture with a cycle-level reference model and
// an expected-word scoreboard drained by an independent monitor.
module tb_analog_capture;
    import analog_capture_pkg::*;

    localparam int W    = 6;
    localparam int FL   = 4;
    localparam int SD   = 16;
    localparam int HMAX = 20000;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] analog_in = '0;
    logic         start = 1'b0;
    logic [7:0]   burst_len = '0;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         busy;
    logic         done;
    logic         overrun;
    state_t       dbg_state;

    always #5 clk = ~clk;

    analog_capture #(.WIDTH(W), .FILTER_LEN(FL), .SAMPLE_DIV(SD)) dut (
        .clk       (clk),
        .rst       (rst),
        .analog_in (analog_in),
        .start     (start),
        .burst_len (burst_len),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun),
        .dbg_state (dbg_state)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_words = 0;
    int n_done = 0;
    int cyc = 0;
    logic [W-1:0] last_word = '0;
    logic [W-1:0] hist [0:HMAX-1];
    logic [W-1:0] exp_q[$];

    // stimulus knobs for the burst driver
    logic [W-1:0] base_v = '0;
    logic [W-1:0] pulse_mask = '0;
    int pulse_off = -100;
    int pulse_len = 0;
    int rnd_an = 0;
    int rdy_rand = 0;
    int rdy_low_until = 0;
    int restart_at = -1;
    int rst_at = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Filtered word in use at sample edge e: per bit, the value of the most
    // recent run of FL identical synchronized samples (lines are read 2 edges late).
    function automatic logic [W-1:0] filt_at(input int e);
        logic [W-1:0] r;
        bit same;
        r = '0;
        for (int b = 0; b < W; b++) begin
            for (int j = e - 3; j >= FL - 1; j--) begin
                same = 1'b1;
                for (int k = 1; k < FL; k++)
                    if (hist[j-k][b] != hist[j][b]) same = 1'b0;
                if (same) begin
                    r[b] = hist[j][b];
                    break;
                end
            end
        end
        return r;
    endfunction

    // ---------------- reference model ----------------
    bit m_busy = 0, m_valid = 0, m_ovr = 0, m_done = 0;
    int m_len = 0, m_cnt = 0, m_next = 0, m_last = 0;

    initial forever begin
        bit acc;
        @(posedge clk);
        if (cyc < HMAX) hist[cyc] = rst ? '0 : analog_in;
        if (rst) begin
            m_busy = 0; m_valid = 0; m_ovr = 0; m_done = 0;
            exp_q.delete();
        end else begin
            acc = m_valid && out_ready;
            if (m_done) begin
                m_done = 0;
                m_busy = 0;
            end else if (!m_busy) begin
                if (start) begin
                    m_busy = 1;
                    m_len  = (burst_len == 0) ? 256 : int'(burst_len);
                    m_cnt  = 0;
                    m_ovr  = 0;
                    m_next = cyc + SD;
                end
            end else begin
                if (m_cnt < m_len && cyc == m_next) begin
                    if (!m_valid || acc) begin
                        exp_q.push_back(filt_at(cyc));
                        m_valid = 1;
                    end else begin
                        m_ovr = 1;
                    end
                    m_cnt++;
                    m_next = cyc + SD + 2;
                    m_last = cyc;
                end else if (acc) begin
                    m_valid = 0;
                end
                m_done = (m_cnt == m_len) && (cyc > m_last) && !m_valid;
            end
        end
        cyc++;
    end

    // ---------------- monitor / scoreboard ----------------
    initial forever begin
        logic [W-1:0] e;
        @(negedge clk);
        if (rst) begin
            check("reset_outputs", {out_data, out_valid, busy, done, overrun}, '0);
        end else begin
            check("ctrl{valid,busy,done,ovr}", {out_valid, busy, done, overrun},
                  {m_valid, m_busy, m_done, m_ovr});
            if (done) n_done++;
            if (out_valid && out_ready) begin
                n_words++;
                last_word = out_data;
                if (exp_q.size() == 0) begin
                    check("word_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("word", out_data, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic burst(input logic [7:0] bl, output int words, output int dones, output int lat);
        int w0, d0;
        bit ended;
        w0 = n_words; d0 = n_done; lat = -1; ended = 0;
        burst_len = bl;
        start = 1'b1;
        tick();
        for (int t = 0; t < 6000; t++) begin
            start = (t == restart_at);
            if (t == restart_at) burst_len = 8'd1;
            if (rnd_an != 0) begin
                if ($urandom_range(0, 3) == 0) analog_in = W'($urandom);
            end else begin
                analog_in = (t + 1 >= pulse_off && t + 1 < pulse_off + pulse_len)
                            ? (base_v ^ pulse_mask) : base_v;
            end
            out_ready = (t + 1 < rdy_low_until) ? 1'b0
                      : ((rdy_rand != 0) ? 1'($urandom_range(0, 1)) : 1'b1);
            if (t == rst_at) rst = 1'b1;
            tick();
            if (lat < 0 && out_valid) lat = t + 1;
            if (!busy) begin
                ended = 1;
                break;
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        check("burst_terminates", 32'(ended), 1);
        words = n_words - w0;
        dones = n_done - d0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int words, dones, lat;
        #1;
        idle(6);
        check("reset_state", {out_data, out_valid, busy, done, overrun}, '0);
        check("reset_fsm_idle", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        base_v = 6'b101010;
        analog_in = base_v;
        idle(12);

        // steady input, always ready
        burst(8'd3, words, dones, lat);
        check("basic_words", words, 3);
        check("basic_done", dones, 1);
        check("basic_latency", lat, 16);
        check("basic_overrun", 32'(overrun), 0);
        check("basic_last_word", last_word, 6'b101010);
        idle(10);

        // 5-cycle pulse landing just early enough to be captured
        pulse_mask = 6'b000001; pulse_len = 5; pulse_off = 10;
        burst(8'd1, words, dones, lat);
        check("pulse_captured", last_word, 6'b101011);
        idle(12);
        // the same pulse one cycle later misses the sample point
        pulse_off = 11;
        burst(8'd1, words, dones, lat);
        check("pulse_too_late", last_word, 6'b101010);
        idle(12);
        // single-cycle glitch is filtered out
        pulse_off = 8; pulse_len = 1;
        burst(8'd1, words, dones, lat);
        check("glitch_filtered", last_word, 6'b101010);
        pulse_len = 0;
        idle(12);

        // consumer stalls: second sample overruns, done waits for acceptance
        rdy_low_until = 44;
        burst(8'd2, words, dones, lat);
        check("stall_words", words, 1);
        check("stall_done", dones, 1);
        check("stall_overrun", 32'(overrun), 1);
        rdy_low_until = 0;
        idle(6);

        // burst_len 0 means 256
        burst(8'd0, words, dones, lat);
        check("len256_words", words, 256);
        check("len256_done", dones, 1);
        check("len256_overrun_cleared", 32'(overrun), 0);
        idle(6);

        // reset after the second of five samples
        rst_at = 39;
        burst(8'd5, words, dones, lat);
        check("midrst_outputs", {out_data, out_valid, busy, done, overrun}, '0);
        check("midrst_words", words, 2);
        check("midrst_no_done", dones, 0);
        idle(10);
        rst = 1'b0;
        rst_at = -1;
        idle(10);
        burst(8'd5, words, dones, lat);
        check("after_rst_words", words, 5);
        check("after_rst_done", dones, 1);
        idle(6);

        // start while busy is ignored
        restart_at = 20;
        burst(8'd4, words, dones, lat);
        check("restart_words", words, 4);
        check("restart_done", dones, 1);
        restart_at = -1;
        idle(6);

        // randomized bursts with random consumer and moving inputs
        rnd_an = 1; rdy_rand = 1;
        for (int i = 0; i < 8; i++) begin
            burst(8'($urandom_range(1, 10)), words, dones, lat);
            check("rand_done", dones, 1);
            idle($urandom_range(2, 8));
        end
        rnd_an = 0; rdy_rand = 0;
        idle(4);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
